// File: rtl/titan_wb_pkg.sv
// Shared definitions for the titan_core Wishbone arbiter: FSM encoding,
// grant identifiers and the watchdog counter sizing helper.
package titan_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic GNT_ID_I = 1'b0;
    localparam logic GNT_ID_D = 1'b1;

    localparam logic [3:0] SEL_FULL = 4'hF;

    // Watchdog counter width: enough to hold the limit, kept within 8..16 bits.
    function automatic int unsigned timeout_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 8)
            w = 8;
        if (w > 16)
            w = 16;
        return w;
    endfunction

endpackage

// File: rtl/titan_wb_timeout.sv
// Bus watchdog: counts stalled strobe cycles and emits a one-cycle expiry
// pulse when the limit is reached. A limit of zero removes the counter.
module titan_wb_timeout
    import titan_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = timeout_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk_i, rst_i, run, clear};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

            logic [CNT_W-1:0] count;

            // An expiry needs a live stall; a real response in the same cycle wins.
            assign expired = run && !clear && (count == LIMIT);

            // NOTE: state updates use <= so every flop samples pre-edge values;
            // blocking assignments here would create order-dependent simulation.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    count <= '0;
                end else if (clear || expired) begin
                    count <= '0;
                end else if (run) begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/titan_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with
// round-robin grant, grant held for the whole cycle, and a hung-slave watchdog.
module titan_wb_arbiter
    import titan_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_FIRST     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] iwbs_addr_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,

    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_we_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,

    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    arb_state_t state, state_next;
    logic       last_grant, last_grant_next;
    logic       req_i, req_d;
    logic       timeout_err;
    logic       wd_run, wd_clear;

    assign req_i = iwbs_cyc_i & iwbs_stb_i;
    assign req_d = dwbs_cyc_i & dwbs_stb_i;

    // ------------------------------------------------------------------
    // Grant state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            last_grant <= DATA_FIRST ? GNT_ID_I : GNT_ID_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can leave a latch behind.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (req_i && req_d) begin
                    if (last_grant == GNT_ID_D) begin
                        state_next      = GNT_I;
                        last_grant_next = GNT_ID_I;
                    end else begin
                        state_next      = GNT_D;
                        last_grant_next = GNT_ID_D;
                    end
                end else if (req_i) begin
                    state_next      = GNT_I;
                    last_grant_next = GNT_ID_I;
                end else if (req_d) begin
                    state_next      = GNT_D;
                    last_grant_next = GNT_ID_D;
                end
            end
            GNT_I: begin
                if (!iwbs_cyc_i)
                    state_next = IDLE;
            end
            GNT_D: begin
                if (!dwbs_cyc_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared bus mux. Strobe is gated by cyc so a master abort ends the
    // bus cycle in the same cycle cyc falls.
    // ------------------------------------------------------------------
    always_comb begin
        wbm_addr_o = '0;
        wbm_dat_o  = '0;
        wbm_sel_o  = '0;
        wbm_we_o   = 1'b0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        unique case (state)
            GNT_I: begin
                wbm_addr_o = iwbs_addr_i;
                wbm_sel_o  = SEL_FULL;
                wbm_cyc_o  = iwbs_cyc_i;
                wbm_stb_o  = iwbs_cyc_i & iwbs_stb_i;
            end
            GNT_D: begin
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_we_o   = dwbs_we_i;
                wbm_cyc_o  = dwbs_cyc_i;
                wbm_stb_o  = dwbs_cyc_i & dwbs_stb_i;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response routing: only the granted port with cyc still high sees
    // ack/err, which discards a response racing a master abort.
    // ------------------------------------------------------------------
    always_comb begin
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        unique case (state)
            GNT_I: begin
                iwbs_ack_o = wbm_ack_i & iwbs_cyc_i;
                iwbs_err_o = (wbm_err_i | timeout_err) & iwbs_cyc_i;
            end
            GNT_D: begin
                dwbs_ack_o = wbm_ack_i & dwbs_cyc_i;
                dwbs_err_o = (wbm_err_i | timeout_err) & dwbs_cyc_i;
            end
            default: ;
        endcase
    end

    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;

    // ------------------------------------------------------------------
    // Watchdog: counts strobe cycles with no slave response.
    // ------------------------------------------------------------------
    assign wd_run   = wbm_stb_o & ~wbm_ack_i & ~wbm_err_i;
    assign wd_clear = (state == IDLE) | wbm_ack_i | wbm_err_i;

    titan_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run     (wd_run),
        .clear   (wd_clear),
        .expired (timeout_err)
    );

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Directed testbench for titan_wb_arbiter with a 10-cycle-or-less watchdog
// (TIMEOUT_CYCLES = 8) and data-first arbitration.
module tb_titan_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] iwbs_addr_i;
    logic        iwbs_cyc_i, iwbs_stb_i;
    logic [31:0] iwbs_dat_o;
    logic        iwbs_ack_o, iwbs_err_o;
    logic [31:0] dwbs_addr_i, dwbs_dat_i;
    logic [3:0]  dwbs_sel_i;
    logic        dwbs_we_i, dwbs_cyc_i, dwbs_stb_i;
    logic [31:0] dwbs_dat_o;
    logic        dwbs_ack_o, dwbs_err_o;
    logic [31:0] wbm_addr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int checks = 0;
    int errors = 0;

    titan_wb_arbiter #(
        .TIMEOUT_CYCLES (8),
        .DATA_FIRST     (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .iwbs_addr_i (iwbs_addr_i),
        .iwbs_cyc_i  (iwbs_cyc_i),
        .iwbs_stb_i  (iwbs_stb_i),
        .iwbs_dat_o  (iwbs_dat_o),
        .iwbs_ack_o  (iwbs_ack_o),
        .iwbs_err_o  (iwbs_err_o),
        .dwbs_addr_i (dwbs_addr_i),
        .dwbs_dat_i  (dwbs_dat_i),
        .dwbs_sel_i  (dwbs_sel_i),
        .dwbs_we_i   (dwbs_we_i),
        .dwbs_cyc_i  (dwbs_cyc_i),
        .dwbs_stb_i  (dwbs_stb_i),
        .dwbs_dat_o  (dwbs_dat_o),
        .dwbs_ack_o  (dwbs_ack_o),
        .dwbs_err_o  (dwbs_err_o),
        .wbm_addr_o  (wbm_addr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        iwbs_addr_i = '0; iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
        dwbs_addr_i = '0; dwbs_dat_i = '0; dwbs_sel_i = '0;
        dwbs_we_i   = 1'b0; dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
        wbm_dat_i   = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        #12;
        // ---- reset values ----
        check("rst_cyc",  32'(wbm_cyc_o), 32'd0);
        check("rst_stb",  32'(wbm_stb_o), 32'd0);
        check("rst_we",   32'(wbm_we_o),  32'd0);
        check("rst_sel",  32'(wbm_sel_o), 32'd0);
        check("rst_addr", wbm_addr_o,     32'd0);
        check("rst_dat",  wbm_dat_o,      32'd0);
        check("rst_resp", 32'({iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o}), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // ---- single instruction fetch ----
        iwbs_addr_i = 32'h100; iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
        #1 check("if_idle_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();
        check("if_cyc",  32'(wbm_cyc_o), 32'd1);
        check("if_stb",  32'(wbm_stb_o), 32'd1);
        check("if_addr", wbm_addr_o, 32'h100);
        check("if_sel",  32'(wbm_sel_o), 32'hF);
        check("if_we",   32'(wbm_we_o), 32'd0);
        check("if_wdat", wbm_dat_o, 32'd0);
        check("if_noack", 32'(iwbs_ack_o), 32'd0);
        tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEADBEEF;
        #1;
        check("if_ack",   32'(iwbs_ack_o), 32'd1);
        check("if_rdat",  iwbs_dat_o, 32'hDEADBEEF);
        check("if_dack0", 32'(dwbs_ack_o), 32'd0);
        check("if_err0",  32'(iwbs_err_o), 32'd0);
        tick();
        idle_inputs();
        #1 check("if_rel_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();

        // ---- contention: D, I, D, I with a dead cycle between grants ----
        pulse_reset();
        iwbs_addr_i = 32'h0000_0400; dwbs_addr_i = 32'h0000_8000;
        iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
        dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        #1 check("rr_idle_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            wbm_ack_i = 1'b1;
            #1;
            check($sformatf("rr%0d_addr", k), wbm_addr_o, exp_d ? 32'h0000_8000 : 32'h0000_0400);
            check($sformatf("rr%0d_dack", k), 32'(dwbs_ack_o), 32'(exp_d));
            check($sformatf("rr%0d_iack", k), 32'(iwbs_ack_o), 32'(!exp_d));
            tick();
            wbm_ack_i = 1'b0;
            if (exp_d) begin
                dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
            end else begin
                iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
            end
            #1 check($sformatf("rr%0d_rel", k), 32'(wbm_cyc_o), 32'd0);
            tick();
            iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
            dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
            #1 check($sformatf("rr%0d_idle", k), 32'(wbm_cyc_o), 32'd0);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // ---- data store ----
        dwbs_addr_i = 32'h2000; dwbs_dat_i = 32'h12345678; dwbs_sel_i = 4'b0011;
        dwbs_we_i = 1'b1; dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        tick();
        check("st_we",   32'(wbm_we_o), 32'd1);
        check("st_sel",  32'(wbm_sel_o), 32'b0011);
        check("st_dat",  wbm_dat_o, 32'h12345678);
        check("st_addr", wbm_addr_o, 32'h2000);
        check("st_noack", 32'(dwbs_ack_o), 32'd0);
        wbm_ack_i = 1'b1;
        #1;
        check("st_ack",  32'(dwbs_ack_o), 32'd1);
        check("st_iack", 32'(iwbs_ack_o), 32'd0);
        tick();
        idle_inputs();
        tick();

        // ---- watchdog expiry: err exactly once, 8 cycles after stb rises ----
        dwbs_addr_i = 32'h3000; dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            check($sformatf("wd_err_c%0d", c), 32'(dwbs_err_o), 32'(c == 8));
            check($sformatf("wd_ack_c%0d", c), 32'(dwbs_ack_o), 32'd0);
            tick();
        end
        idle_inputs();
        #1 check("wd_rel_cyc", 32'(wbm_cyc_o), 32'd0);
        tick();
        tick();

        // ---- real ack in the timeout cycle wins ----
        dwbs_addr_i = 32'h3004; dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        tick();
        for (int c = 0; c < 8; c++)
            tick();
        wbm_ack_i = 1'b1;
        #1;
        check("wd_race_ack", 32'(dwbs_ack_o), 32'd1);
        check("wd_race_err", 32'(dwbs_err_o), 32'd0);
        tick();
        idle_inputs();
        tick();

        // ---- simultaneous ack and err both forwarded ----
        iwbs_addr_i = 32'h104; iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
        tick();
        wbm_ack_i = 1'b1; wbm_err_i = 1'b1;
        #1;
        check("ae_ack", 32'(iwbs_ack_o), 32'd1);
        check("ae_err", 32'(iwbs_err_o), 32'd1);
        tick();
        idle_inputs();
        tick();

        // ---- master abort discards a racing ack ----
        dwbs_addr_i = 32'h3008; dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        tick();
        dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0; wbm_ack_i = 1'b1;
        #1;
        check("ab_ack", 32'(dwbs_ack_o), 32'd0);
        check("ab_cyc", 32'(wbm_cyc_o), 32'd0);
        check("ab_stb", 32'(wbm_stb_o), 32'd0);
        tick();
        idle_inputs();
        tick();

        // ---- asynchronous reset mid-transfer ----
        dwbs_addr_i = 32'h300C; dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
        tick();
        check("ar_pre_stb", 32'(wbm_stb_o), 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check("ar_cyc", 32'(wbm_cyc_o), 32'd0);
        check("ar_stb", 32'(wbm_stb_o), 32'd0);
        dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
        iwbs_addr_i = 32'h200; iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1;
        #1 rst_i = 1'b1;
        tick();
        check("ar_gnt_i_cyc",  32'(wbm_cyc_o), 32'd1);
        check("ar_gnt_i_addr", wbm_addr_o, 32'h200);
        check("ar_gnt_i_sel",  32'(wbm_sel_o), 32'hF);
        idle_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
